// File: rtl/garbage_sort_pkg.sv
// Shared constants, types, default filter bank and
// helpers for the garbage-sort CNN front end.
package garbage_sort_pkg;

    localparam int NUM_FILT = 8;
    localparam int PIX_W    = 8;
    localparam int FEAT_W   = 16;
    localparam int ACC_W    = 24;
    localparam int WGT_W    = 8;

    typedef logic [3*PIX_W-1:0]               pix_t;
    typedef logic [2:0][2:0][3*PIX_W-1:0]     win_t;
    typedef logic [FEAT_W-1:0]                feat_t;
    typedef logic [NUM_FILT-1:0][FEAT_W-1:0]  feat_vec_t;
    typedef logic [2:0][2:0][2:0][WGT_W-1:0]  filt_wgt_t;
    typedef logic [NUM_FILT-1:0][2:0][2:0][2:0][WGT_W-1:0] wgt_arr_t;
    typedef logic [NUM_FILT-1:0][WGT_W-1:0]   bias_arr_t;

    // Weights indexed [filter][channel R,G,B][row][col].
    function automatic wgt_arr_t default_wgt();
        wgt_arr_t w;
        w = '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        if (f == 0) begin
                            w[f][ch][r][c] = WGT_W'(1);
                        end else if (f == 1) begin
                            w[f][ch][r][c] = '1;
                        end else if (ch == (f - 2) % 3 && r == 1 && c == 1) begin
                            w[f][ch][r][c] = WGT_W'(1);
                        end
                    end
                end
            end
        end
        return w;
    endfunction

    localparam wgt_arr_t  DEF_WGT  = default_wgt();
    localparam bias_arr_t DEF_BIAS = '0;

    function automatic feat_vec_t feat_max(input feat_vec_t a, input feat_vec_t b);
        feat_vec_t m;
        for (int f = 0; f < NUM_FILT; f++) begin
            m[f] = (a[f] > b[f]) ? a[f] : b[f];
        end
        return m;
    endfunction

endpackage

// File: rtl/garbage_sort_top_conv3x3_filter.sv
// One conv filter: 27-tap MAC registered, then
// shift, ReLU and saturation registered.
module conv3x3_filter
    import garbage_sort_pkg::*;
#(
    parameter int                      OUT_SHIFT = 0,
    parameter filt_wgt_t               WGT       = '0,
    parameter logic signed [WGT_W-1:0] BIAS      = '0
) (
    input  logic  clk,
    input  win_t  win,
    output feat_t feat
);
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic signed [ACC_W-1:0] sh;
    feat_t                   feat_d, feat_q;

    // Signed sum of unsigned pixels times signed weights.
    always_comb begin
        sum_d = ACC_W'(BIAS);
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sum_d = sum_d
                        + ACC_W'($signed({1'b0, win[r][c][PIX_W*(2-ch) +: PIX_W]}))
                        * ACC_W'($signed(WGT[ch][r][c]));
                end
            end
        end
    end

    // Scale down, clamp negatives to zero, cap at feature max.
    always_comb begin
        sh     = sum_q >>> OUT_SHIFT;
        feat_d = sh[FEAT_W-1:0];
        if (sh[ACC_W-1]) begin
            feat_d = '0;
        end else if (|sh[ACC_W-2:FEAT_W]) begin
            feat_d = '1;
        end
    end

    // Two pipeline registers; datapath needs no reset.
    always_ff @(posedge clk) begin
        sum_q  <= sum_d;
        feat_q <= feat_d;
    end

    assign feat = feat_q;

endmodule

// File: rtl/garbage_sort_top.sv
// Garbage-sort CNN front end: line buffers, 3x3 window,
// eight conv filters, ReLU and 2x2 stride-2 max pool.
module garbage_sort_top
    import garbage_sort_pkg::*;
#(
    parameter int        IMG_W     = 32,
    parameter int        IMG_H     = 32,
    parameter int        OUT_SHIFT = 0,
    parameter wgt_arr_t  WGT       = DEF_WGT,
    parameter bias_arr_t BIAS      = DEF_BIAS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*PIX_W-1:0]         d_in,
    input  logic                       conv_start,
    output logic [NUM_FILT*FEAT_W-1:0] pool_out,
    output logic                       pool_valid
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PB = 1 << (CW - 1);

    logic [CW-1:0] col_d, col_q, cc0_d, cc0_q, cc1_q, cc2_q;
    logic [RW-1:0] row_d, row_q;
    logic          rp0_d, rp0_q, rp1_q, rp2_q;
    logic          v0_d, v0_q, v1_q, v2_q;
    pix_t          lb0_d [IMG_W];
    pix_t          lb0_q [IMG_W];
    pix_t          lb1_d [IMG_W];
    pix_t          lb1_q [IMG_W];
    win_t          win_d, win_q;
    feat_vec_t     feat, m;
    feat_vec_t     hold_d, hold_q;
    feat_vec_t     pbuf_d [PB];
    feat_vec_t     pbuf_q [PB];
    feat_vec_t     pool_d, pool_q;
    logic          pv_d, pv_q;

    // Accept a pixel: update line buffers, window and counters.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        win_d = win_q;
        v0_d  = 1'b0;
        cc0_d = cc0_q;
        rp0_d = rp0_q;
        if (conv_start) begin
            lb0_d[col_q] = d_in;
            lb1_d[col_q] = lb0_q[col_q];
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = d_in;
            v0_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
            cc0_d = col_q - CW'(2);
            rp0_d = row_q[0];
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Pair horizontally, then vertically via the row buffer.
    always_comb begin
        hold_d = hold_q;
        pbuf_d = pbuf_q;
        pool_d = pool_q;
        pv_d   = 1'b0;
        m      = feat_max(hold_q, feat);
        if (v2_q) begin
            if (!cc2_q[0]) begin
                hold_d = feat;
            end else if (!rp2_q) begin
                pbuf_d[cc2_q[CW-1:1]] = m;
            end else begin
                pool_d = feat_max(pbuf_q[cc2_q[CW-1:1]], m);
                pv_d   = 1'b1;
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            pool_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            v0_q   <= v0_d;
            v1_q   <= v0_q;
            v2_q   <= v1_q;
            pool_q <= pool_d;
            pv_q   <= pv_d;
        end
    end

    // Datapath storage, always rewritten before use.
    always_ff @(posedge clk) begin
        lb0_q  <= lb0_d;
        lb1_q  <= lb1_d;
        win_q  <= win_d;
        cc0_q  <= cc0_d;
        cc1_q  <= cc0_q;
        cc2_q  <= cc1_q;
        rp0_q  <= rp0_d;
        rp1_q  <= rp0_q;
        rp2_q  <= rp1_q;
        hold_q <= hold_d;
        pbuf_q <= pbuf_d;
    end

    for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
        conv3x3_filter #(
            .OUT_SHIFT (OUT_SHIFT),
            .WGT       (WGT[f]),
            .BIAS      (BIAS[f])
        ) u_filt (
            .clk  (clk),
            .win  (win_q),
            .feat (feat[f])
        );
    end

    assign pool_out   = pool_q;
    assign pool_valid = pv_q;

endmodule

// File: tb/tb_garbage_sort_top.sv
// Bench for garbage_sort_top: directed 4x4 frames,
// saturation, mid-frame reset, random 8x6 vs model.
module tb_garbage_sort_top;
    import garbage_sort_pkg::*;

    localparam int C_W     = 8;
    localparam int C_H     = 6;
    localparam int C_SHIFT = 1;

    function automatic wgt_arr_t sat_wgt();
        wgt_arr_t w;
        w = DEF_WGT;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[0][ch][r][c] = 8'd127;
        return w;
    endfunction

    localparam wgt_arr_t SAT_WGT = sat_wgt();

    logic         clk;
    logic         a_rst, rst_bc;
    logic [23:0]  a_din, b_din, c_din;
    logic         a_start, b_start, c_start;
    logic [127:0] a_out, b_out, c_out;
    logic         a_pv, b_pv, c_pv;

    garbage_sort_top #(.IMG_W(4), .IMG_H(4), .OUT_SHIFT(0)) u_dut (
        .clk(clk), .rst(a_rst), .d_in(a_din), .conv_start(a_start),
        .pool_out(a_out), .pool_valid(a_pv));

    garbage_sort_top #(.IMG_W(4), .IMG_H(4), .OUT_SHIFT(0),
                       .WGT(SAT_WGT)) u_sat (
        .clk(clk), .rst(rst_bc), .d_in(b_din), .conv_start(b_start),
        .pool_out(b_out), .pool_valid(b_pv));

    garbage_sort_top #(.IMG_W(C_W), .IMG_H(C_H),
                       .OUT_SHIFT(C_SHIFT)) u_rnd (
        .clk(clk), .rst(rst_bc), .d_in(c_din), .conv_start(c_start),
        .pool_out(c_out), .pool_valid(c_pv));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_pulses = 0, b_pulses = 0, c_pulses = 0;
    int a_edge = 0;
    logic [127:0] a_val = '0, b_val = '0;
    logic [127:0] exp_q[$];
    logic [23:0]  img [C_H][C_W];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_pv) begin
            a_pulses++;
            a_edge = cyc;
            a_val  = a_out;
        end
        if (b_pv) begin
            b_pulses++;
            b_val = b_out;
        end
        if (c_pv) begin
            c_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_extra_pulse: got %h, expected no pulse", c_out);
            end else begin
                chk("rnd_pool", c_out, exp_q.pop_front());
            end
        end
    endtask

    function automatic logic [127:0] pack8(int f0, int f1, int f2, int f3,
                                           int f4, int f5, int f6, int f7);
        return {16'(f7), 16'(f6), 16'(f5), 16'(f4),
                16'(f3), 16'(f2), 16'(f1), 16'(f0)};
    endfunction

    function automatic logic [23:0] pat(int mode, int i);
        return (mode == 0) ? 24'h010203 : 24'(i % 4);
    endfunction

    task automatic a_frame(input int mode, input int st_at, input int st_len,
                           output int first);
        first = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == st_at) begin
                for (int s = 0; s < st_len; s++) begin
                    a_start = 1'b0;
                    tick();
                end
            end
            a_din   = pat(mode, i);
            a_start = 1'b1;
            if (i == 0) first = cyc + 1;
            tick();
        end
        a_start = 1'b0;
    endtask

    function automatic int chan(logic [23:0] p, int ch);
        return int'(p[8*(2-ch) +: 8]);
    endfunction

    // Behavioural conv at output position (r,c) of the random frame.
    function automatic int conv_ref(int f, int r, int c);
        int s;
        s = 0;
        if (f < 2) begin
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    for (int ch = 0; ch < 3; ch++)
                        s += chan(img[r+dr][c+dc], ch);
            if (f == 1) s = -s;
        end else begin
            s = chan(img[r+1][c+1], (f - 2) % 3);
        end
        s = s >>> C_SHIFT;
        if (s < 0) s = 0;
        if (s > 65535) s = 65535;
        return s;
    endfunction

    typedef struct packed {
        logic [1:0]   mode;
        logic [4:0]   st_at;
        logic [3:0]   st_len;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [4];
    int   first, p0;
    logic [127:0] cst;

    initial begin
        cst    = pack8(54, 0, 1, 2, 3, 1, 2, 3);
        tbl[0] = '{mode: 2'd0, st_at: 5'd0,  st_len: 4'd0, exp: cst};
        tbl[1] = '{mode: 2'd1, st_at: 5'd0,  st_len: 4'd0,
                   exp: pack8(18, 0, 0, 0, 2, 0, 0, 2)};
        tbl[2] = '{mode: 2'd1, st_at: 5'd9,  st_len: 4'd5,
                   exp: pack8(18, 0, 0, 0, 2, 0, 0, 2)};
        tbl[3] = '{mode: 2'd0, st_at: 5'd15, st_len: 4'd2, exp: cst};

        a_rst = 1'b0; rst_bc = 1'b0;
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        a_din = 24'h123456; b_din = 24'hFFFFFF; c_din = 24'h654321;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_pool_out", a_out, '0);
            chk("reset_pool_valid", 128'(a_pv), '0);
        end
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_rst = 1'b1; rst_bc = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            p0 = a_pulses;
            a_frame(int'(tbl[v].mode), int'(tbl[v].st_at),
                    int'(tbl[v].st_len), first);
            for (int k = 0; k < 10; k++) tick();
            chk("vec_pulse_count", 128'(a_pulses - p0), 128'(1));
            chk("vec_pool_value", a_val, tbl[v].exp);
            chk("vec_latency", 128'(a_edge - first),
                128'(15 + int'(tbl[v].st_len) + 3));
            chk("vec_hold", a_out, tbl[v].exp);
        end

        p0 = b_pulses;
        for (int i = 0; i < 16; i++) begin
            b_din = 24'hFFFFFF;
            b_start = 1'b1;
            tick();
        end
        b_start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("sat_pulse_count", 128'(b_pulses - p0), 128'(1));
        chk("sat_value", b_val, pack8(65535, 0, 255, 255, 255, 255, 255, 255));

        p0 = a_pulses;
        for (int i = 0; i < 7; i++) begin
            a_din = pat(1, i);
            a_start = 1'b1;
            tick();
        end
        a_rst = 1'b0;
        a_din = 24'h555555;
        tick();
        a_rst = 1'b1;
        a_frame(0, 0, 0, first);
        for (int k = 0; k < 8; k++) tick();
        chk("midrst_pulse_count", 128'(a_pulses - p0), 128'(1));
        chk("midrst_value", a_val, cst);
        chk("midrst_latency", 128'(a_edge - first), 128'(18));

        p0 = c_pulses;
        for (int fr = 0; fr < 3; fr++) begin
            for (int r = 0; r < C_H; r++)
                for (int c = 0; c < C_W; c++)
                    img[r][c] = 24'($urandom);
            for (int br = 0; br < (C_H - 2) / 2; br++) begin
                for (int bc = 0; bc < (C_W - 2) / 2; bc++) begin
                    logic [127:0] e;
                    e = '0;
                    for (int f = 0; f < 8; f++) begin
                        int mx;
                        mx = 0;
                        for (int dr = 0; dr < 2; dr++)
                            for (int dc = 0; dc < 2; dc++)
                                if (conv_ref(f, 2*br+dr, 2*bc+dc) > mx)
                                    mx = conv_ref(f, 2*br+dr, 2*bc+dc);
                        e[16*f +: 16] = 16'(mx);
                    end
                    exp_q.push_back(e);
                end
            end
            for (int r = 0; r < C_H; r++) begin
                for (int c = 0; c < C_W; c++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        c_start = 1'b0;
                        repeat ($urandom_range(1, 3)) tick();
                    end
                    c_din = img[r][c];
                    c_start = 1'b1;
                    tick();
                end
            end
        end
        c_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("rnd_pulse_count", 128'(c_pulses - p0), 128'(18));
        chk("rnd_queue_left", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
